// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode at the ID/EX boundary.
// Sequences multi-cycle MULT/DIV and freezes upstream until done.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Valid_in,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic              Stall_in,
  input  logic              Flush,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              Valid_out,
  output logic              MulDivStart,
  output logic              Stall_out,
  output logic              Illegal
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC);

  localparam logic [CNT_W-1:0] MUL_LD =
    CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LD =
    CNT_W'(DIV_CYCLES - 2);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_MULT = 4'b1010;
  localparam logic [3:0] C_DIV  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               hit, hit_n;
  logic [CTRL_W-1:0]  ctrl, ctrl_n;
  logic               vld, vld_n;
  logic               start, start_n;
  logic               stl, stl_n;
  logic               ill, ill_n;

  logic [3:0]         dcode;
  logic               dill;
  logic               dmul;
  logic               ddiv;

  always_comb begin
    dcode = C_ADD;
    dill  = 1'b0;
    dmul  = 1'b0;
    ddiv  = 1'b0;
    unique case (ALUOp)
      2'b00: dcode = C_ADD;
      2'b01: dcode = C_SUB;
      2'b11: dcode = C_OR;
      2'b10: begin
        case (Funct)
          6'b100000: dcode = C_ADD;
          6'b100010: dcode = C_SUB;
          6'b100100: dcode = C_AND;
          6'b100101: dcode = C_OR;
          6'b100111: dcode = C_NOR;
          6'b101010: dcode = C_SLT;
          6'b000000: dcode = C_SLL;
          6'b000010: dcode = C_SRL;
          6'b011000: begin
            dcode = C_MULT;
            dmul  = 1'b1;
          end
          6'b011010: begin
            dcode = C_DIV;
            ddiv  = 1'b1;
          end
          default: begin
            dcode = C_ADD;
            dill  = 1'b1;
          end
        endcase
      end
      default: dcode = C_ADD;
    endcase
  end

  // hit delays the zero count by one edge so Valid_out lands
  // exactly MUL_CYCLES/DIV_CYCLES edges after the accept edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hit_n   = hit;
    ctrl_n  = ctrl;
    vld_n   = vld;
    start_n = 1'b0;
    stl_n   = stl;
    ill_n   = ill;
    if (Flush) begin
      state_n = IDLE;
      cnt_n   = '0;
      hit_n   = 1'b0;
      vld_n   = 1'b0;
      stl_n   = 1'b0;
      ill_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Stall_in) begin
            start_n = start;
          end else if (Valid_in) begin
            ctrl_n = CTRL_W'(dcode);
            ill_n  = dill;
            if (dmul || ddiv) begin
              state_n = BUSY;
              start_n = 1'b1;
              vld_n   = 1'b0;
              stl_n   = 1'b1;
              cnt_n   = ddiv ? DIV_LD : MUL_LD;
              hit_n   = 1'b0;
            end else begin
              vld_n = 1'b1;
              stl_n = 1'b0;
            end
          end else begin
            vld_n = 1'b0;
            ill_n = 1'b0;
          end
        end
        BUSY: begin
          vld_n = 1'b0;
          stl_n = 1'b1;
          hit_n = (cnt == '0);
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end
          if (hit) begin
            state_n = DONE;
            vld_n   = 1'b1;
            hit_n   = 1'b0;
          end
        end
        DONE: begin
          vld_n = 1'b1;
          stl_n = 1'b1;
          if (!Stall_in) begin
            state_n = IDLE;
            vld_n   = 1'b0;
            stl_n   = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          vld_n   = 1'b0;
          stl_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hit   <= 1'b0;
      ctrl  <= '0;
      vld   <= 1'b0;
      start <= 1'b0;
      stl   <= 1'b0;
      ill   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hit   <= hit_n;
      ctrl  <= ctrl_n;
      vld   <= vld_n;
      start <= start_n;
      stl   <= stl_n;
      ill   <= ill_n;
    end
  end

  assign ALUControl  = ctrl;
  assign Valid_out   = vld;
  assign MulDivStart = start;
  assign Stall_out   = stl;
  assign Illegal     = ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: scoreboard on Valid_out plus
// directed cycle checks for mul/div, stall, flush and reset.
module tb_alu_ctrl_seq;

  localparam int CW = 4;
  localparam int MC = 4;
  localparam int DC = 32;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Valid_in;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic          Stall_in;
  logic          Flush;
  logic [CW-1:0] ALUControl;
  logic          Valid_out;
  logic          MulDivStart;
  logic          Stall_out;
  logic          Illegal;

  int errs   = 0;
  int checks = 0;

  logic [CW:0] sb[$];

  logic [5:0] fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                         6'h27, 6'h2a, 6'h00, 6'h02};
  logic [3:0] cd [8] = '{4'b0010, 4'b0110, 4'b0000,
                         4'b0001, 4'b1100, 4'b0111,
                         4'b1000, 4'b1001};

  alu_ctrl_seq #(
    .CTRL_W    (CW),
    .MUL_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Valid_in   (Valid_in),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .Stall_in   (Stall_in),
    .Flush      (Flush),
    .ALUControl (ALUControl),
    .Valid_out  (Valid_out),
    .MulDivStart(MulDivStart),
    .Stall_out  (Stall_out),
    .Illegal    (Illegal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] op,
                       input logic [5:0] f);
    Valid_in = v;
    ALUOp    = op;
    Funct    = f;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [5:0] f,
                       input logic [3:0] code,
                       input logic il);
    drive(1'b1, op, f);
    sb.push_back({il, code});
  endtask

  // a fresh result is any valid that is not a stalled hold
  logic rst_q   = 1'b0;
  logic stall_q = 1'b0;
  logic pv      = 1'b0;

  always @(posedge Clk) begin
    rst_q   = Rst_n;
    stall_q = Stall_in;
  end

  always @(negedge Clk) begin
    logic [CW:0] e;
    if (rst_q && Valid_out && !(pv && stall_q)) begin
      chk("sb_avail", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_ctrl", ALUControl, e[CW-1:0]);
        chk("sb_ill", Illegal, e[CW]);
      end
    end
    pv = rst_q & Valid_out;
  end

  task automatic run_md(input logic [5:0] f,
                        input logic [3:0] code,
                        input int n,
                        input int s0,
                        input int s1);
    int last;
    last = (s1 >= n) ? s1 + 1 : n + 1;
    issue(2'b10, f, code, 1'b0);
    tick();
    chk("md_start0", MulDivStart, 1);
    chk("md_stall0", Stall_out, 1);
    chk("md_valid0", Valid_out, 0);
    chk("md_ctrl0", ALUControl, code);
    drive(1'b1, 2'b00, 6'h00);
    for (int k = 1; k <= last; k++) begin
      Stall_in = (k >= s0) && (k <= s1);
      tick();
      chk("md_start", MulDivStart, 0);
      chk("md_valid", Valid_out, (k >= n) && (k < last));
      chk("md_stall", Stall_out, k < last);
      if (k < last) chk("md_ctrl", ALUControl, code);
    end
    Stall_in = 1'b0;
    drive(1'b0, 2'b00, 6'h00);
  endtask

  initial begin
    Rst_n    = 1'b0;
    Stall_in = 1'b0;
    Flush    = 1'b0;
    drive(1'b1, 2'b10, 6'h20);
    tick();
    tick();
    chk("rst_ctrl", ALUControl, 0);
    chk("rst_valid", Valid_out, 0);
    chk("rst_start", MulDivStart, 0);
    chk("rst_stall", Stall_out, 0);
    chk("rst_ill", Illegal, 0);

    Rst_n = 1'b1;
    issue(2'b10, 6'h20, 4'b0010, 1'b0);
    tick();
    chk("rel_valid", Valid_out, 1);
    chk("rel_ctrl", ALUControl, 4'b0010);

    for (int i = 0; i < 8; i++) begin
      issue(2'b10, fn[i], cd[i], 1'b0);
      tick();
      chk("sweep_valid", Valid_out, 1);
    end
    issue(2'b10, 6'h3f, 4'b0010, 1'b1);
    tick();
    chk("ill_flag", Illegal, 1);
    issue(2'b00, 6'h3f, 4'b0010, 1'b0);
    tick();
    issue(2'b01, 6'h3f, 4'b0110, 1'b0);
    tick();
    issue(2'b11, 6'h3f, 4'b0001, 1'b0);
    tick();
    drive(1'b0, 2'b00, 6'h00);
    tick();
    chk("idle_valid", Valid_out, 0);
    chk("idle_ill", Illegal, 0);

    run_md(6'h18, 4'b1010, MC, 1, 0);
    run_md(6'h1a, 4'b1011, DC, 1, 0);
    run_md(6'h18, 4'b1010, MC, 3, 7);

    issue(2'b10, 6'h24, 4'b0000, 1'b0);
    tick();
    Stall_in = 1'b1;
    drive(1'b1, 2'b10, 6'h22);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ctrl", ALUControl, 4'b0000);
      chk("hold_valid", Valid_out, 1);
    end
    Stall_in = 1'b0;
    issue(2'b10, 6'h25, 4'b0001, 1'b0);
    tick();
    chk("unhold_ctrl", ALUControl, 4'b0001);
    drive(1'b0, 2'b00, 6'h00);
    tick();

    drive(1'b1, 2'b10, 6'h1a);
    tick();
    drive(1'b0, 2'b00, 6'h00);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_flush_stall", Stall_out, 1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_stall", Stall_out, 0);
    chk("flush_valid", Valid_out, 0);
    chk("flush_ctrl", ALUControl, 4'b1011);
    issue(2'b10, 6'h2a, 4'b0111, 1'b0);
    tick();
    chk("post_flush_v", Valid_out, 1);
    drive(1'b1, 2'b10, 6'h20);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_acc_v", Valid_out, 0);
    drive(1'b0, 2'b00, 6'h00);
    tick();

    drive(1'b1, 2'b10, 6'h18);
    tick();
    drive(1'b0, 2'b00, 6'h00);
    tick();
    tick();
    Rst_n = 1'b0;
    tick();
    chk("mrst_ctrl", ALUControl, 0);
    chk("mrst_valid", Valid_out, 0);
    chk("mrst_start", MulDivStart, 0);
    chk("mrst_stall", Stall_out, 0);
    Rst_n = 1'b1;
    tick();
    chk("mrst_idle", Stall_out, 0);
    issue(2'b10, 6'h20, 4'b0010, 1'b0);
    tick();
    chk("mrst_acc", Valid_out, 1);
    drive(1'b0, 2'b00, 6'h00);
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
